// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/capture stage wrapped around the 8-bit combinational ALU.
//   A request (req_*) is accepted on a valid/ready handshake and its operands
//   are registered. The stage then drives the ALU (alu_*) for DRIVE_CYCLES
//   cycles, captures alu_d_out into a result register, and offers the result
//   on the res_* valid/ready handshake. alu_oe is high only while EXEC is
//   active, so the ALU's tri-state output is never sampled outside EXEC.
//
// Handshake rule (both sides): a transfer happens at a rising edge where
//   valid and ready are both 1. While valid is high and not yet accepted,
//   the producer holds its payload stable. req_ready depends on res_ready
//   in DONE, so a new op can be accepted in the cycle the old result leaves.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake; req_cmd/req_a/req_b payload
//   alu_oe/alu_command/alu_a/alu_b   drive to the ALU
//   alu_d_out                 ALU result
//   res_valid/res_ready       result handshake; res_data/res_cmd/res_err payload
//   op_count                  completed result handshakes, saturating
//   dbg_state                 FSM state for observation: 0 IDLE, 1 EXEC, 2 DONE
//
// Optional feature macro: ALU_DIV0_CHECK_EN
//   When defined, DIV with b==0 never enables the ALU; the op still spends
//   DRIVE_CYCLES in EXEC and captures res_data=16'hFFFF with res_err=1.
//   When undefined, res_err stays 0 and DIV by zero captures the ALU output.

module alu_issue_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRIVE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  output logic             alu_oe,
  output logic [3:0]       alu_command,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [15:0]      alu_d_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [3:0]       res_cmd,
  output logic             res_err,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  // Drive counter counts DRIVE_CYCLES-1 down to 0; capture happens at 0.
  localparam int CW = (DRIVE_CYCLES > 1) ? $clog2(DRIVE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRIVE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic              div0_q, div0_d;
  logic [15:0]       res_data_q, res_data_d;
  logic [3:0]        res_cmd_q, res_cmd_d;
  logic              res_err_q, res_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic              accept;
  logic              div0_hit;

`ifdef ALU_DIV0_CHECK_EN
  localparam logic [3:0] OP_DIV = 4'd3;
  assign div0_hit = (req_cmd == OP_DIV) && (req_b == 8'd0);
`else
  assign div0_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    div0_d     = div0_q;
    res_data_d = res_data_q;
    res_cmd_d  = res_cmd_q;
    res_err_d  = res_err_q;
    op_count_d = op_count_q;
    req_ready  = 1'b0;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          // A suppressed divide-by-zero never enabled the ALU, so its bus
          // content is meaningless and is replaced by the all-ones marker.
          res_data_d = div0_q ? 16'hFFFF : alu_d_out;
          res_cmd_d  = cmd_q;
          res_err_d  = div0_q;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        req_ready = res_ready;
        if (res_ready) begin
          if (op_count_q != '1) op_count_d = op_count_q + CNT_W'(1);
          state_d = S_IDLE;
          accept  = req_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      cmd_d   = req_cmd;
      a_d     = req_a;
      b_d     = req_b;
      div0_d  = div0_hit;
      cnt_d   = CNT_LOAD;
      state_d = S_EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      div0_q     <= 1'b0;
      res_data_q <= '0;
      res_cmd_q  <= '0;
      res_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      div0_q     <= div0_d;
      res_data_q <= res_data_d;
      res_cmd_q  <= res_cmd_d;
      res_err_q  <= res_err_d;
      op_count_q <= op_count_d;
    end
  end

  // Operands stay on the ALU inputs outside EXEC; only alu_oe gates the ALU.
  assign alu_oe      = (state_q == S_EXEC) && !div0_q;
  assign alu_command = cmd_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign res_valid   = (state_q == S_DONE);
  assign res_data    = res_data_q;
  assign res_cmd     = res_cmd_q;
  assign res_err     = res_err_q;
  assign op_count    = op_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int CNT_W        = 16;
  localparam int DRIVE_CYCLES = 1;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,
                         OP_DIV = 4'd3,  OP_SHL = 4'd4,  OP_SHR = 4'd5,
                         OP_AND = 4'd6,  OP_OR  = 4'd7,  OP_XOR = 4'd8,
                         OP_NOT = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [3:0]       req_cmd;
  logic [7:0]       req_a, req_b;
  logic             alu_oe;
  logic [3:0]       alu_command;
  logic [7:0]       alu_a, alu_b;
  logic [15:0]      alu_d_out;
  logic             res_valid, res_ready;
  logic [15:0]      res_data;
  logic [3:0]       res_cmd;
  logic             res_err;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       dbg_state;

  alu_issue_ctrl #(.CNT_W(CNT_W), .DRIVE_CYCLES(DRIVE_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_oe(alu_oe), .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
    .alu_d_out(alu_d_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cmd(res_cmd), .res_err(res_err),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU stand-in and reference ----------------
  function automatic logic [15:0] alu_ref(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      OP_ADD:  return 16'(a) + 16'(b);
      OP_SUB:  return 16'(a) - 16'(b);
      OP_MUL:  return 16'(a) * 16'(b);
      OP_DIV:  return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
      OP_SHL:  return {8'h00, 8'(a << b[2:0])};
      OP_SHR:  return {8'h00, 8'(a >> b[2:0])};
      OP_AND:  return {8'h00, a & b};
      OP_OR:   return {8'h00, a | b};
      OP_XOR:  return {8'h00, a ^ b};
      OP_NOT:  return {8'h00, ~a};
      OP_INC:  return 16'(a) + 16'd1;
      OP_DEC:  return 16'(a) - 16'd1;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic exp_err(input logic [3:0] c, input logic [7:0] b);
`ifdef ALU_DIV0_CHECK_EN
    return (c == OP_DIV) && (b == 8'd0);
`else
    return 1'b0;
`endif
  endfunction

  // A disabled ALU drives a recognisable junk pattern so any capture
  // outside a live EXEC shows up in the result.
  assign alu_d_out = alu_oe ? alu_ref(alu_command, alu_a, alu_b) : 16'hBAD0;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: {err, cmd, data} of every accepted request, in order.
  logic [20:0]      exp_q[$];
  logic [CNT_W-1:0] exp_count;

  always @(negedge clk) begin
    logic [20:0] e;
    logic        er;
    if (rst) begin
      exp_q.delete();
      exp_count = '0;
    end else begin
      check("op_count", 32'(op_count), 32'(exp_count));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got data %0h with no outstanding request", res_data);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(e[15:0]));
          check("res_cmd",  32'(res_cmd),  32'(e[19:16]));
          check("res_err",  32'(res_err),  32'(e[20]));
        end
        if (exp_count != '1) exp_count = exp_count + 1'b1;
      end
      if (req_valid && req_ready) begin
        er = exp_err(req_cmd, req_b);
        exp_q.push_back({er, req_cmd, er ? 16'hFFFF : alu_ref(req_cmd, req_a, req_b)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge
  // with req_valid still high. acc_cyc is the cycle count at acceptance.
  task automatic send(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, output int acc_cyc);
    int  n    = 0;
    bit  done = 0;
    acc_cyc   = -1;
    req_valid = 1'b1;
    req_cmd   = c;
    req_a     = a;
    req_b     = b;
    while (!done && n < 200) begin
      @(negedge clk);
      if (req_ready) begin
        done    = 1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got req_ready=0 for 200 cycles expected 1");
    end
  endtask

  // Returns at a falling edge where res_valid is seen (or the bound expired).
  task automatic wait_res(input string name);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(res_valid), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[10];
  bit   rand_en;

  initial begin
    int t1, t2, tmp;
    bit oe_seen;

    vecs[0] = '{OP_ADD, 8'h0F, 8'h01, 16'h0010};
    vecs[1] = '{OP_SUB, 8'h05, 8'h03, 16'h0002};
    vecs[2] = '{OP_XOR, 8'hAA, 8'h0F, 16'h00A5};
    vecs[3] = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01};
    vecs[4] = '{OP_AND, 8'hF0, 8'h3C, 16'h0030};
    vecs[5] = '{OP_OR,  8'hF0, 8'h0F, 16'h00FF};
    vecs[6] = '{OP_INC, 8'h7F, 8'h00, 16'h0080};
    vecs[7] = '{OP_SHL, 8'h81, 8'h01, 16'h0002};
    vecs[8] = '{OP_DIV, 8'h10, 8'h04, 16'h0004};
    vecs[9] = '{OP_SHR, 8'h80, 8'h07, 16'h0001};

    rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0;
    res_ready = 1'b0; rand_en = 1'b0;

    // 1. reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_alu_oe",    32'(alu_oe),    32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_cmd",   32'(res_cmd),   32'd0);
    check("rst_res_err",   32'(res_err),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 5. reset during EXEC drops the op
    res_ready = 1'b1;
    send(OP_INC, 8'h7F, 8'h00, tmp);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("t5_in_exec", 32'(dbg_state), 32'd1);
    check("t5_oe_exec", 32'(alu_oe),    32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_state_idle", 32'(dbg_state), 32'd0);
    check("t5_res_valid",  32'(res_valid), 32'd0);
    check("t5_op_count",   32'(op_count),  32'd0);
    check("t5_req_ready",  32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // 2. ADD latency
    send(OP_ADD, 8'h0F, 8'h01, tmp);
    req_valid = 1'b0;
    @(negedge clk);
    check("t2_exec_no_valid", 32'(res_valid), 32'd0);
    check("t2_exec_oe",       32'(alu_oe),    32'd1);
    check("t2_exec_a",        32'(alu_a),     32'h0F);
    repeat (DRIVE_CYCLES) @(posedge clk);
    #1;
    @(negedge clk);
    check("t2_latency_valid", 32'(res_valid), 32'd1);
    check("t2_data",          32'(res_data),  32'h0010);
    check("t2_cmd",           32'(res_cmd),   32'(OP_ADD));
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_op_count", 32'(op_count), 32'd1);
    @(posedge clk); #1;

    // 3. MUL with stalled consumer
    res_ready = 1'b0;
    send(OP_MUL, 8'hFF, 8'hFF, tmp);
    req_valid = 1'b0;
    wait_res("t3_valid");
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_data",  32'(res_data),  32'hFE01);
      check("t3_req_ready",  32'(req_ready), 32'd0);
      check("t3_oe_off",     32'(alu_oe),    32'd0);
      check("t3_hold_valid", 32'(res_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;

    // 4. back-to-back SUB then XOR
    send(OP_SUB, 8'h05, 8'h03, t1);
    send(OP_XOR, 8'hAA, 8'h0F, t2);
    req_valid = 1'b0;
    check("t4_spacing", 32'(t2 - t1), 32'(DRIVE_CYCLES + 1));
    wait_res("t4_valid");
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_op_count", 32'(op_count), 32'd4);
    @(posedge clk); #1;

    // 6. divide by zero
    res_ready = 1'b0;
    oe_seen   = 1'b0;
    send(OP_DIV, 8'h10, 8'h00, tmp);
    req_valid = 1'b0;
    for (int i = 0; i < 50 && !res_valid; i++) begin
      @(negedge clk);
      oe_seen = oe_seen | alu_oe;
    end
    check("t6_valid", 32'(res_valid), 32'd1);
`ifdef ALU_DIV0_CHECK_EN
    check("t6_oe_never", 32'(oe_seen),  32'd0);
    check("t6_err",      32'(res_err),  32'd1);
    check("t6_data",     32'(res_data), 32'hFFFF);
`else
    check("t6_oe_used",  32'(oe_seen),  32'd1);
    check("t6_err",      32'(res_err),  32'd0);
    check("t6_data",     32'(res_data), 32'hFFFF);
`endif
    @(posedge clk); #1;
    res_ready = 1'b1;
    send(OP_DIV, 8'h10, 8'h04, tmp);
    req_valid = 1'b0;
    wait_res("t6b_valid");
    check("t6b_err",  32'(res_err),  32'd0);
    check("t6b_data", 32'(res_data), 32'h0004);
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].cmd, vecs[i].a, vecs[i].b, tmp);
      req_valid = 1'b0;
      wait_res("vec_valid");
      check("vec_data", 32'(res_data), 32'(vecs[i].exp_data));
      check("vec_cmd",  32'(res_cmd),  32'(vecs[i].cmd));
      @(posedge clk); #1;
    end

    // randomized traffic with a randomly stalling consumer
    rand_en = 1'b1;
    fork
      begin
        logic [3:0] c;
        logic [7:0] a, b;
        for (int i = 0; i < 150; i++) begin
          c = 4'($urandom_range(0, 11));
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          if (c == OP_DIV && $urandom_range(0, 3) == 0) b = 8'h00;
          send(c, a, b, tmp);
          if ($urandom_range(0, 2) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        req_valid = 1'b0;
        rand_en   = 1'b0;
      end
      begin
        while (rand_en) begin
          @(posedge clk); #1;
          if (rand_en) res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
